ext_mem_lat: RTL

Parametrised, synthesizable-style external memory model. It is the next generation of the bench-side memory behind the accelerator's `mem_req`/`mem_resp` ports. It adds:
- a configurable fixed response latency with pipelined outstanding requests,
- an optional request-throttle gap,
- sub-word typed access with sign/zero extension and byte-merge writes,
- range/alignment error reporting and access counters.

It sits in the test harness between the ASIC memory ports and a word-organised backing array. The bench preloads that array hierarchically.

---
 rtl/ext_mem_pkg.sv | 38 +++
 rtl/ext_mem_lane.sv | 53 +++++
 rtl/ext_mem_lat.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ext_mem_pkg.sv
// Shared command/type encodings, response record and size helper for the
// latency-modelling external memory.
package ext_mem_pkg;

    localparam logic [4:0] M_XRD = 5'd0;
    localparam logic [4:0] M_XWR = 5'd1;

    localparam logic [2:0] MT_B  = 3'd0;
    localparam logic [2:0] MT_H  = 3'd1;
    localparam logic [2:0] MT_W  = 3'd2;
    localparam logic [2:0] MT_D  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd4;
    localparam logic [2:0] MT_HU = 3'd5;
    localparam logic [2:0] MT_WU = 3'd6;

    // Address is held at the widest supported width; the top narrows it to ADDR_W.
    typedef struct packed {
        logic [63:0] addr;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic [63:0] data;
    } resp_t;

    typedef enum logic {
        ST_OPEN,
        ST_GAP
    } rdy_state_e;

    function automatic logic [3:0] size_of(input logic [2:0] typ);
        case (typ[1:0])
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/ext_mem_lane.sv
// Lane logic shared by both access paths: extracts and extends a read lane,
// and merges write bytes into a word under a byte enable.
module ext_mem_lane
    import ext_mem_pkg::*;
(
    input  logic [2:0]  typ_i,
    input  logic [2:0]  lane_i,
    input  logic [63:0] word_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] rdata_o,
    output logic [63:0] merged_o
);

    logic [63:0] shifted;
    logic [63:0] wshift;
    logic [63:0] byteMask;
    logic [7:0]  sizeBe;
    logic [7:0]  be;
    logic        signExt;

    always_comb begin
        shifted  = word_i >> {lane_i, 3'b000};
        wshift   = wdata_i << {lane_i, 3'b000};
        signExt  = !typ_i[2] && (typ_i[1:0] != 2'b11);
        rdata_o  = shifted;
        sizeBe   = 8'hFF;
        byteMask = '0;
        case (typ_i[1:0])
            2'd0: begin
                sizeBe  = 8'h01;
                rdata_o = {{56{signExt & shifted[7]}}, shifted[7:0]};
            end
            2'd1: begin
                sizeBe  = 8'h03;
                rdata_o = {{48{signExt & shifted[15]}}, shifted[15:0]};
            end
            2'd2: begin
                sizeBe  = 8'h0F;
                rdata_o = {{32{signExt & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                sizeBe  = 8'hFF;
                rdata_o = shifted;
            end
        endcase
        be = sizeBe << lane_i;
        for (int i = 0; i < 8; i++) begin
            byteMask[8*i +: 8] = {8{be[i]}};
        end
        merged_o = (word_i & ~byteMask) | (wshift & byteMask);
    end

endmodule

// File: rtl/ext_mem_lat.sv
// Harness-side memory model with fixed response latency, optional accept
// throttling, typed sub-word access, error flagging and access counters.
module ext_mem_lat
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W      = 40,
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4,
    parameter int READY_GAP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_ready_o,
    input  logic              mem_req_valid_i,
    input  logic [ADDR_W-1:0] mem_req_addr_i,
    input  logic [4:0]        mem_req_cmd_i,
    input  logic [2:0]        mem_req_typ_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    output logic              mem_resp_valid_o,
    output logic [ADDR_W-1:0] mem_resp_addr_o,
    output logic [4:0]        mem_resp_cmd_o,
    output logic [2:0]        mem_resp_typ_o,
    output logic [DATA_W-1:0] mem_resp_data_o,
    output logic              err_o,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [63:0] mem [0:DEPTH_WORDS-1];

    rdy_state_e         state_q, state_d;
    logic [15:0]        gapCnt_q, gapCnt_d;
    logic [LATENCY-1:0] pipeValid_q;
    resp_t              pipe_q [LATENCY];
    resp_t              respIn_d;
    logic [31:0]        rdCount_q, rdCount_d;
    logic [31:0]        wrCount_q, wrCount_d;
    logic               err_q, err_d;

    logic              accept;
    logic              isWrite;
    logic              reqErr;
    logic [ADDR_W-1:0] wordIdx;
    logic [IDX_W-1:0]  memIdx;
    logic [3:0]        reqSize;
    logic [63:0]       rdWord;
    logic [63:0]       laneRdata;
    logic [63:0]       laneMerged;

    assign mem_req_ready_o = (state_q == ST_OPEN) && !reset;
    assign accept          = mem_req_valid_i && mem_req_ready_o;
    assign isWrite         = (mem_req_cmd_i == M_XWR);
    assign wordIdx         = mem_req_addr_i >> 3;
    assign memIdx          = wordIdx[IDX_W-1:0];
    assign reqSize         = size_of(mem_req_typ_i);
    assign rdWord          = mem[memIdx];

    assign reqErr = (wordIdx >= ADDR_W'(DEPTH_WORDS))
                 || ((mem_req_addr_i[2:0] & 3'(reqSize - 4'd1)) != 3'd0)
                 || (mem_req_typ_i == 3'd7)
                 || ((mem_req_cmd_i != M_XRD) && (mem_req_cmd_i != M_XWR));

    ext_mem_lane u_lane (
        .typ_i    (mem_req_typ_i),
        .lane_i   (mem_req_addr_i[2:0]),
        .word_i   (rdWord),
        .wdata_i  (64'(mem_req_data_i)),
        .rdata_o  (laneRdata),
        .merged_o (laneMerged)
    );

    // The backing array is deliberately left out of reset so preloaded and
    // previously written contents survive a harness reset.
    always_ff @(posedge clk) begin
        if (accept && isWrite && !reqErr) begin
            mem[memIdx] <= laneMerged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_OPEN;
            gapCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gapCnt_q <= gapCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gapCnt_d = gapCnt_q;
        case (state_q)
            ST_OPEN: begin
                if (accept && (READY_GAP > 0)) begin
                    state_d  = ST_GAP;
                    gapCnt_d = 16'(READY_GAP);
                end
            end
            ST_GAP: begin
                gapCnt_d = gapCnt_q - 16'd1;
                if (gapCnt_q == 16'd1) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    // Error requests still get a response and still count, but carry zero data.
    always_comb begin
        respIn_d  = '0;
        rdCount_d = rdCount_q;
        wrCount_d = wrCount_q;
        err_d     = err_q;
        if (accept) begin
            respIn_d.addr = 64'(mem_req_addr_i);
            respIn_d.cmd  = mem_req_cmd_i;
            respIn_d.typ  = mem_req_typ_i;
            respIn_d.data = reqErr ? 64'd0 : (isWrite ? laneMerged : laneRdata);
            if (mem_req_cmd_i == M_XRD) rdCount_d = rdCount_q + 32'd1;
            if (mem_req_cmd_i == M_XWR) wrCount_d = wrCount_q + 32'd1;
            if (reqErr) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipeValid_q <= '0;
            rdCount_q   <= '0;
            wrCount_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipeValid_q[0] <= accept;
            pipe_q[0]      <= respIn_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipe_q[i]      <= pipe_q[i-1];
            end
            rdCount_q <= rdCount_d;
            wrCount_q <= wrCount_d;
            err_q     <= err_d;
        end
    end

    assign mem_resp_valid_o = pipeValid_q[LATENCY-1];
    assign mem_resp_addr_o  = ADDR_W'(pipe_q[LATENCY-1].addr);
    assign mem_resp_cmd_o   = pipe_q[LATENCY-1].cmd;
    assign mem_resp_typ_o   = pipe_q[LATENCY-1].typ;
    assign mem_resp_data_o  = DATA_W'(pipe_q[LATENCY-1].data);
    assign err_o            = err_q;
    assign rd_count_o       = rdCount_q;
    assign wr_count_o       = wrCount_q;

endmodule
